// File: rtl/jedro_1_writeback_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module   : jedro_1_writeback_if                                          |
// | Purpose  : Bundles the LSU issue/return, ALU handshake and register-file |
// |            write signals of the jedro-1 writeback stage.                 |
// | Revision : 1.0 - initial release                                         |
// ----------------------------------------------------------------------------
interface jedro_1_writeback_if;
  logic        iss_valid_i;
  logic [3:0]  iss_ctrl_i;
  logic [1:0]  iss_off_i;
  logic        lsu_valid_i;
  logic [31:0] lsu_rdata_i;
  logic [4:0]  lsu_regdest_i;
  logic        alu_valid_i;
  logic        alu_ready_o;
  logic [31:0] alu_wdata_i;
  logic [4:0]  alu_regdest_i;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic [1:0]  loads_pend_o;

  // Pipeline side: drives issue/return/ALU, observes the write port.
  modport master (
    output iss_valid_i, iss_ctrl_i, iss_off_i,
    output lsu_valid_i, lsu_rdata_i, lsu_regdest_i,
    output alu_valid_i, alu_wdata_i, alu_regdest_i,
    input  alu_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, loads_pend_o
  );

  // Writeback stage side.
  modport slave (
    input  iss_valid_i, iss_ctrl_i, iss_off_i,
    input  lsu_valid_i, lsu_rdata_i, lsu_regdest_i,
    input  alu_valid_i, alu_wdata_i, alu_regdest_i,
    output alu_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, loads_pend_o
  );
endinterface
`default_nettype wire

// File: rtl/jedro_1_writeback.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module   : jedro_1_writeback                                             |
// | Purpose  : Merges formatted LSU load results and ALU results onto the    |
// |            single register-file write port. Loads always win; losing     |
// |            ALU results wait in a small in-order skid FIFO.               |
// | Revision : 1.0 - initial release                                         |
// ----------------------------------------------------------------------------
module jedro_1_writeback #(
  parameter int LOAD_LATENCY  = 3,
  parameter int ALU_BUF_DEPTH = 2
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  jedro_1_writeback_if.slave wb
);
  localparam int PTR_W = $clog2(ALU_BUF_DEPTH);
  localparam int HEAD  = LOAD_LATENCY - 1;

  logic [LOAD_LATENCY-1:0]      meta_valid;
  logic [LOAD_LATENCY-1:0][2:0] meta_f3;
  logic [LOAD_LATENCY-1:0][1:0] meta_off;

  logic [31:0]    fifo_data [ALU_BUF_DEPTH];
  logic [4:0]     fifo_rd   [ALU_BUF_DEPTH];
  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;
  logic           fifo_empty;
  logic           fifo_full;

  logic        load_issue;
  logic        alu_accept;
  logic        push;
  logic        pop;
  logic        sel_valid;
  logic [4:0]  sel_rd;
  logic [31:0] sel_data;
  logic [31:0] load_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Extra pointer bit distinguishes full from empty when indices match.
  assign fifo_empty     = (wr_ptr == rd_ptr);
  assign fifo_full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                          (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign wb.alu_ready_o = rstn_i & ~fifo_full;
  assign alu_accept     = wb.alu_valid_i & wb.alu_ready_o;
  assign load_issue     = wb.iss_valid_i & ~wb.iss_ctrl_i[3];

  // Load metadata travels alongside the LSU so the head matches returning data.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      meta_valid <= '0;
      meta_f3    <= '0;
      meta_off   <= '0;
    end else begin
      meta_valid[0] <= load_issue;
      meta_f3[0]    <= wb.iss_ctrl_i[2:0];
      meta_off[0]   <= wb.iss_off_i;
      for (int i = 1; i < LOAD_LATENCY; i++) begin
        meta_valid[i] <= meta_valid[i-1];
        meta_f3[i]    <= meta_f3[i-1];
        meta_off[i]   <= meta_off[i-1];
      end
    end
  end

  // Align and extend the returning word; data without an issue record writes zero.
  always_comb begin
    ld_byte = 8'h00;
    case (meta_off[HEAD])
      2'd0:    ld_byte = wb.lsu_rdata_i[7:0];
      2'd1:    ld_byte = wb.lsu_rdata_i[15:8];
      2'd2:    ld_byte = wb.lsu_rdata_i[23:16];
      default: ld_byte = wb.lsu_rdata_i[31:24];
    endcase
    ld_half = meta_off[HEAD][1] ? wb.lsu_rdata_i[31:16] : wb.lsu_rdata_i[15:0];
    case (meta_f3[HEAD])
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  load_data = {24'h000000, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  load_data = {16'h0000, ld_half};
      3'b010:  load_data = wb.lsu_rdata_i;
      default: load_data = 32'h0;
    endcase
    if (!meta_valid[HEAD]) begin
      load_data = 32'h0;
    end
  end

  // Source select: load, then oldest buffered ALU, then ALU bypass.
  always_comb begin
    sel_valid = 1'b0;
    sel_rd    = 5'd0;
    sel_data  = 32'h0;
    pop       = 1'b0;
    push      = alu_accept;
    if (wb.lsu_valid_i) begin
      sel_valid = 1'b1;
      sel_rd    = wb.lsu_regdest_i;
      sel_data  = load_data;
    end else if (!fifo_empty) begin
      sel_valid = 1'b1;
      sel_rd    = fifo_rd[rd_ptr[PTR_W-1:0]];
      sel_data  = fifo_data[rd_ptr[PTR_W-1:0]];
      pop       = 1'b1;
    end else if (alu_accept) begin
      sel_valid = 1'b1;
      sel_rd    = wb.alu_regdest_i;
      sel_data  = wb.alu_wdata_i;
      push      = 1'b0;
    end
  end

  // Skid storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_data[wr_ptr[PTR_W-1:0]] <= wb.alu_wdata_i;
      fifo_rd[wr_ptr[PTR_W-1:0]]   <= wb.alu_regdest_i;
    end
  end

  // FIFO pointers; reset empties the buffer and drops held ALU results.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Registered write port; x0 results are consumed without a write.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wb.rf_we_o    <= 1'b0;
      wb.rf_waddr_o <= 5'd0;
      wb.rf_wdata_o <= 32'h0;
    end else begin
      wb.rf_we_o <= sel_valid && (sel_rd != 5'd0);
      if (sel_valid) begin
        wb.rf_waddr_o <= sel_rd;
        wb.rf_wdata_o <= sel_data;
      end
    end
  end

  // Outstanding-load counter for the hazard unit, saturating at both ends.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wb.loads_pend_o <= 2'd0;
    end else begin
      case ({load_issue, wb.lsu_valid_i})
        2'b10: if (wb.loads_pend_o != 2'd3) wb.loads_pend_o <= wb.loads_pend_o + 2'd1;
        2'b01: if (wb.loads_pend_o != 2'd0) wb.loads_pend_o <= wb.loads_pend_o - 2'd1;
        default: wb.loads_pend_o <= wb.loads_pend_o;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_jedro_1_writeback.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module   : tb_jedro_1_writeback                                          |
// | Purpose  : Self-checking bench for jedro_1_writeback: directed scenarios |
// |            plus random traffic against a queue-based reference model.    |
// | Revision : 1.0 - initial release                                         |
// ----------------------------------------------------------------------------
module tb_jedro_1_writeback;
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  jedro_1_writeback_if bus ();

  jedro_1_writeback #(.LOAD_LATENCY(3), .ALU_BUF_DEPTH(2)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .wb     (bus)
  );

  typedef struct { int due; logic [2:0] f3; logic [1:0] off; } ld_t;
  typedef struct { logic [4:0] rd; logic [31:0] data; } alu_t;

  ld_t  ldq[$];
  alu_t aq[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   model_pend = 0;
  logic chk_en = 1'b1;
  logic acc_last = 1'b0;
  logic exp_ready = 1'b0;
  logic        cur_we = 0, nxt_we = 0, cur_zero = 1, nxt_zero = 1;
  logic [4:0]  cur_waddr = 0, nxt_waddr = 0;
  logic [31:0] cur_wdata = 0, nxt_wdata = 0;
  logic [1:0]  cur_pend = 0, nxt_pend = 0;

  // Reference formatting written from the load-type rules as shifts.
  function automatic logic [31:0] fmt(logic [2:0] f3, logic [1:0] off, logic [31:0] w);
    logic [31:0] sh;
    sh = w >> (8 * off);
    case (f3)
      3'd0: return {{24{sh[7]}}, sh[7:0]};
      3'd4: return {24'h0, sh[7:0]};
      3'd1: begin sh = w >> (16 * off[1]); return {{16{sh[15]}}, sh[15:0]}; end
      3'd5: begin sh = w >> (16 * off[1]); return {16'h0, sh[15:0]}; end
      3'd2: return w;
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare process: DUT outputs against model every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("rf_we", 32'(bus.rf_we_o), 32'(cur_we));
      check("loads_pend", 32'(bus.loads_pend_o), 32'(cur_pend));
      check("alu_ready", 32'(bus.alu_ready_o), 32'(exp_ready));
      if (cur_we || cur_zero) begin
        check("rf_waddr", 32'(bus.rf_waddr_o), 32'(cur_waddr));
        check("rf_wdata", bus.rf_wdata_o, cur_wdata);
      end
    end
  end

  // One cycle: drive inputs, then advance the model to the next output state.
  task automatic step(input logic rn, input logic iv, input logic [3:0] ctrl,
                      input logic [1:0] off, input logic av, input logic [31:0] ad,
                      input logic [4:0] ard, input logic [31:0] ldata, input logic [4:0] lrd);
    logic lv, sv, acc;
    logic [4:0]  srd;
    logic [31:0] sdata;
    ld_t  e;
    alu_t a;
    @(posedge clk); #1;
    cur_we = nxt_we; cur_waddr = nxt_waddr; cur_wdata = nxt_wdata;
    cur_pend = nxt_pend; cur_zero = nxt_zero;
    cyc++;
    lv = rn && (ldq.size() > 0) && (ldq[0].due == cyc);
    rstn = rn;
    bus.iss_valid_i = iv; bus.iss_ctrl_i = ctrl; bus.iss_off_i = off;
    bus.lsu_valid_i = lv; bus.lsu_rdata_i = ldata; bus.lsu_regdest_i = lrd;
    bus.alu_valid_i = av; bus.alu_wdata_i = ad; bus.alu_regdest_i = ard;
    exp_ready = rn && (aq.size() < 2);
    acc = av && exp_ready;
    acc_last = acc;
    if (!rn) begin
      ldq.delete(); aq.delete(); model_pend = 0;
      nxt_we = 0; nxt_waddr = 0; nxt_wdata = 0; nxt_pend = 0; nxt_zero = 1;
    end else begin
      nxt_zero = 0; sv = 0; srd = 0; sdata = 0;
      if (lv) begin
        e = ldq.pop_front(); sv = 1; srd = lrd; sdata = fmt(e.f3, e.off, ldata);
      end else if (aq.size() > 0) begin
        a = aq.pop_front(); sv = 1; srd = a.rd; sdata = a.data;
      end else if (acc) begin
        sv = 1; srd = ard; sdata = ad; acc = 0;
      end
      if (acc) aq.push_back('{ard, ad});
      if (iv && !ctrl[3]) ldq.push_back('{cyc + 3, ctrl[2:0], off});
      model_pend = model_pend + int'(iv && !ctrl[3]) - int'(lv);
      if (model_pend > 3) model_pend = 3;
      if (model_pend < 0) model_pend = 0;
      nxt_we = sv && (srd != 0);
      if (nxt_we) begin nxt_waddr = srd; nxt_wdata = sdata; end
      nxt_pend = 2'(model_pend);
    end
  endtask

  task automatic idle();
    step(1, 0, 4'h0, 2'd0, 0, 32'h0, 5'd0, 32'h0, 5'd0);
  endtask

  logic        ha_v;
  logic [31:0] ha_d;
  logic [4:0]  ha_rd;
  int          alu_idx;

  initial begin
    // Model pins for the load formatting rules.
    check("fmt_lb", fmt(3'd0, 2'd3, 32'h80112233), 32'hFFFFFF80);
    check("fmt_lbu", fmt(3'd4, 2'd3, 32'h80112233), 32'h00000080);
    check("fmt_lh", fmt(3'd1, 2'd2, 32'h80112233), 32'hFFFF8011);
    check("fmt_lhu", fmt(3'd5, 2'd0, 32'h80112233), 32'h00002233);

    repeat (3) step(0, 0, 4'h0, 2'd0, 0, 32'h0, 5'd0, 32'h0, 5'd0);
    idle();
    #3 check("reset_we", 32'(bus.rf_we_o), 32'd0);
    check("reset_ready", 32'(bus.alu_ready_o), 32'd1);

    // LW round trip.
    step(1, 1, 4'b0010, 2'd0, 0, 32'h0, 5'd0, 32'h0, 5'd0);
    idle(); idle();
    step(1, 0, 4'h0, 2'd0, 0, 32'h0, 5'd0, 32'hDEADBEEF, 5'd5);
    idle();
    #3 check("t1_we", 32'(bus.rf_we_o), 32'd1);
    check("t1_waddr", 32'(bus.rf_waddr_o), 32'd5);
    check("t1_wdata", bus.rf_wdata_o, 32'hDEADBEEF);

    // LB / LBU / LH formatting through the DUT.
    step(1, 1, 4'b0000, 2'd3, 0, 32'h0, 5'd0, 32'h0, 5'd0);
    step(1, 1, 4'b0100, 2'd3, 0, 32'h0, 5'd0, 32'h0, 5'd0);
    step(1, 1, 4'b0001, 2'd2, 0, 32'h0, 5'd0, 32'h0, 5'd0);
    step(1, 0, 4'h0, 2'd0, 0, 32'h0, 5'd0, 32'h80112233, 5'd1);
    #3 check("t2_pend3", 32'(bus.loads_pend_o), 32'd3);
    step(1, 0, 4'h0, 2'd0, 0, 32'h0, 5'd0, 32'h80112233, 5'd2);
    #3 check("t2_lb", bus.rf_wdata_o, 32'hFFFFFF80);
    step(1, 0, 4'h0, 2'd0, 0, 32'h0, 5'd0, 32'h80112233, 5'd3);
    #3 check("t2_lbu", bus.rf_wdata_o, 32'h00000080);
    idle();
    #3 check("t2_lh", bus.rf_wdata_o, 32'hFFFF8011);

    // ALU collides with a returning load.
    step(1, 1, 4'b0010, 2'd0, 0, 32'h0, 5'd0, 32'h0, 5'd0);
    idle(); idle();
    step(1, 0, 4'h0, 2'd0, 1, 32'h1, 5'd7, 32'h12345678, 5'd9);
    idle();
    #3 check("t3_load_addr", 32'(bus.rf_waddr_o), 32'd9);
    idle();
    #3 check("t3_alu_addr", 32'(bus.rf_waddr_o), 32'd7);
    check("t3_alu_data", bus.rf_wdata_o, 32'h1);

    // Three back-to-back loads while the ALU streams.
    repeat (3) step(1, 1, 4'b0010, 2'd0, 0, 32'h0, 5'd0, 32'h0, 5'd0);
    alu_idx = 0;
    for (int k = 0; k < 10; k++) begin
      step(1, 0, 4'h0, 2'd0, alu_idx < 4, 32'(100 + alu_idx), 5'(10 + alu_idx),
           32'(k + 1), 5'(20 + k));
      if (acc_last) alu_idx++;
      if (k == 2) begin
        #3 check("t4_ready_full", 32'(bus.alu_ready_o), 32'd0);
      end
    end

    // x0 destinations: no write, but the load still retires.
    step(1, 1, 4'b0010, 2'd0, 0, 32'h0, 5'd0, 32'h0, 5'd0);
    idle(); idle();
    step(1, 0, 4'h0, 2'd0, 0, 32'h0, 5'd0, 32'hCAFEF00D, 5'd0);
    idle();
    #3 check("t5_load_x0_we", 32'(bus.rf_we_o), 32'd0);
    check("t5_pend", 32'(bus.loads_pend_o), 32'd0);
    step(1, 0, 4'h0, 2'd0, 1, 32'h55, 5'd0, 32'h0, 5'd0);
    idle();
    #3 check("t5_alu_x0_we", 32'(bus.rf_we_o), 32'd0);

    // Reset with FIFO full and two loads in flight.
    step(1, 1, 4'b0010, 2'd0, 0, 32'h0, 5'd0, 32'h0, 5'd0);
    step(1, 1, 4'b0010, 2'd0, 0, 32'h0, 5'd0, 32'h0, 5'd0);
    step(1, 1, 4'b0010, 2'd0, 0, 32'h0, 5'd0, 32'h0, 5'd0);
    step(1, 1, 4'b0010, 2'd0, 1, 32'hA1, 5'd11, 32'h111, 5'd12);
    step(1, 0, 4'h0, 2'd0, 1, 32'hA2, 5'd13, 32'h222, 5'd14);
    step(0, 0, 4'h0, 2'd0, 0, 32'h0, 5'd0, 32'h0, 5'd0);
    #3 check("t6_pend_before", 32'(bus.loads_pend_o), 32'd2);
    idle();
    #3 check("t6_we", 32'(bus.rf_we_o), 32'd0);
    check("t6_wdata", bus.rf_wdata_o, 32'h0);
    check("t6_pend", 32'(bus.loads_pend_o), 32'd0);
    check("t6_ready", 32'(bus.alu_ready_o), 32'd1);
    repeat (5) idle();

    // Random traffic with a held-until-accepted ALU producer.
    ha_v = 0; ha_d = 0; ha_rd = 0;
    for (int n = 0; n < 4000; n++) begin
      if (acc_last || !ha_v) begin
        ha_v  = 1'($urandom_range(0, 1));
        ha_d  = $urandom;
        ha_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      end
      step(($urandom_range(0, 299) != 0), 1'($urandom_range(0, 1)),
           {($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7))},
           2'($urandom_range(0, 3)), ha_v, ha_d, ha_rd,
           $urandom, 5'($urandom_range(0, 31)));
    end
    repeat (6) idle();

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
